dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 128, meaning number of DATA_W-bit words stored.
REQ-003 SHALL have parameter READ_LAT, default 2, legal 0..7, meaning wait cycles between read acceptance and response.
REQ-004 SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising clk edge.
REQ-005 Port: clk  input  1  clock.
REQ-006 Port: rst  input  1  synchronous active-high reset.
REQ-007 Port: mem_read  input  1  read request from the control unit (ld).
REQ-008 Port: mem_write  input  1  write request from the control unit (sd).
REQ-009 Port: addr  input  64  byte address from the ALU.
REQ-010 Port: wdata  input  DATA_W  store data.
REQ-011 Port: rdata  output  DATA_W  load data, valid only while rvalid=1.
REQ-012 Port: rvalid  output  1  one-cycle load-data-valid strobe.
REQ-013 Port: stall  output  1  pipeline SHALL hold all request inputs stable while high.
REQ-014 Port: err  output  1  one-cycle strobe for a rejected request.

Function
REQ-015 Word index SHALL be addr[63:3]; addr[2:0]!=0, word index >= DEPTH, or mem_read&mem_write SHALL make a request illegal.
REQ-016 FSM states SHALL be IDLE, READ, WRITE, RESP, ERR; reset state IDLE.
REQ-017 IDLE with mem_read|mem_write high SHALL accept: capture index, wdata, type; drive stall=1 combinationally that cycle.
REQ-018 IDLE transitions: illegal -> ERR; legal write -> WRITE; legal read -> READ if READ_LAT>0, else RESP.
REQ-019 READ SHALL load a down-counter with READ_LAT-1 on entry, hold stall=1, decrement each cycle, go to RESP in the cycle after the counter is 0.
REQ-020 Memory SHALL be read from the captured index on the transition into RESP; rdata registered.
REQ-021 RESP SHALL drive rvalid=1, stall=0 for exactly one cycle, then go to IDLE.
REQ-022 WRITE SHALL drive stall=0, write captured wdata to captured index at the end of that cycle, then go to IDLE.
REQ-023 ERR SHALL drive err=1, stall=0, rdata=0 for one cycle, perform no memory access, then go to IDLE.
REQ-024 Request inputs seen in RESP, WRITE, ERR SHALL be ignored (same held instruction); a new request SHALL only be accepted in IDLE.
REQ-025 Totals: read occupies READ_LAT+2 cycles, write 2, error 2; rvalid and err SHALL never be high together.
REQ-026 A read accepted in the cycle after a WRITE to the same index SHALL return the newly written data.
REQ-027 IDLE with no request SHALL drive stall=0, rvalid=0, err=0.
REQ-028 rdata SHALL hold its last value outside RESP except after reset or ERR (then 0).

Reset
REQ-029 rst=1 SHALL force state IDLE, counter 0, rdata=0, rvalid=0, err=0; stall reflects IDLE decode.
REQ-030 rst during READ or RESP SHALL abandon the read with no rvalid pulse.
REQ-031 rst during WRITE SHALL suppress the pending write; memory contents SHALL otherwise be preserved across reset.
REQ-032 rst takes priority over any request presented in the same cycle.

Verification
REQ-033 Write 0xDEADBEEF_01234567 to addr 0x40, then read 0x40 (READ_LAT=2) -> stall high 3 cycles, rvalid pulse in 4th cycle with rdata 0xDEADBEEF_01234567.
REQ-034 Read at addr 0x41 -> one stall cycle, then err=1 one cycle, rdata=0, no rvalid; memory unchanged.
REQ-035 mem_read=mem_write=1 at addr 0x0, and separately addr=DEPTH*8 -> err pulse each, no memory write.
REQ-036 READ_LAT=0, read at 0x8 -> stall 1 cycle, rvalid next cycle; back-to-back write 0x10 then read 0x10 -> read returns new data.
REQ-037 Assert rst in the WRITE cycle of a write to 0x18 holding 0x5 (old 0x0), then read 0x18 -> rdata 0x0; rst mid-READ -> no rvalid, FSM IDLE next cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time from the pipeline,
// stalls it for the configured read latency and answers with rvalid or err.
module dmem_responder #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 128,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [63:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              stall,
    output logic              err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] LAT_M1 = (READ_LAT > 0) ? 3'(READ_LAT - 1) : 3'd0;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RESP,
        ERR
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [2:0]        cnt_q, cnt_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              req;
    logic              illegal;
    logic [60:0]       word_idx;
    logic [IDX_W-1:0]  req_idx;

    assign req      = mem_read | mem_write;
    assign word_idx = addr[63:3];
    assign req_idx  = word_idx[IDX_W-1:0];
    assign illegal  = (addr[2:0] != 3'd0) | (word_idx >= 61'(DEPTH)) | (mem_read & mem_write);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = req_idx;
                    wdata_d = wdata;
                    if (illegal) begin
                        state_d = ERR;
                        rdata_d = '0;
                    end else if (mem_write) begin
                        state_d = WRITE;
                    end else if (READ_LAT == 0) begin
                        // zero latency: read straight off the request address
                        state_d = RESP;
                        rdata_d = mem[req_idx];
                    end else begin
                        state_d = READ;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            READ: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                    rdata_d = mem[idx_q];
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WRITE:   state_d = IDLE;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage is deliberately not reset; only the pending write is dropped.
    always_ff @(posedge clk) begin
        if (!rst && state_q == WRITE) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign stall  = ((state_q == IDLE) && req) || (state_q == READ);
    assign rvalid = (state_q == RESP) && !rst;
    assign err    = (state_q == ERR) && !rst;
    assign rdata  = rdata_q;

endmodule
